// File: rtl/icache_pkg.sv
// Shared types and constants for the icache tag SRAM controller.
package icache_pkg;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 22;
  localparam int ENTRY_W = TAG_W + 1;

  // One tag SRAM word: bit TAG_W is the valid flag, the rest is the tag.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
  } tag_entry_t;

  // SWEEP clears every entry; RUN arbitrates flush > fill > lookup.
  typedef enum logic [0:0] {
    ST_SWEEP = 1'b0,
    ST_RUN   = 1'b1
  } ctrl_state_e;

  // A stored entry matches when it is valid and its tag equals the request tag.
  function automatic logic entry_hit(input tag_entry_t entry, input logic [TAG_W-1:0] tag);
    return entry.valid && (entry.tag == tag);
  endfunction

  // Build the word written by a fill.
  function automatic tag_entry_t make_entry(input logic valid, input logic [TAG_W-1:0] tag);
    tag_entry_t e;
    e.valid = valid;
    e.tag   = tag;
    return e;
  endfunction

endpackage

// File: rtl/icache_tag_sweep.sv
// Index counter for the invalidate sweep: walks 0..63 writing zero entries.
module icache_tag_sweep
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               step_i,     // a sweep write is issued this cycle
  input  logic               restart_i,  // begin a new sweep at index 0
  output logic [INDEX_W-1:0] addr_o,
  output tag_entry_t         din_o,
  output logic               done_o      // current issue is the last index
);

  logic [INDEX_W-1:0] count_q;
  logic [INDEX_W-1:0] count_d;

  // Next-count: restart wins, otherwise advance once per issued write.
  always_comb begin
    count_d = count_q;
    if (restart_i) begin
      count_d = {INDEX_W{1'b0}};
    end else if (step_i) begin
      // Wraps 63 -> 0 exactly on the exit cycle of the sweep.
      count_d = count_q + {{(INDEX_W-1){1'b0}}, 1'b1};
    end else begin
      count_d = count_q;
    end
  end

  // Counter register; reset leaves the sweep ready to start at index 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= {INDEX_W{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

  assign addr_o = count_q;
  assign din_o  = make_entry(1'b0, {TAG_W{1'b0}});
  assign done_o = (count_q == {INDEX_W{1'b1}});

endmodule

// File: rtl/icache_tag_ctrl.sv
// Arbiter between lookups, fills and flushes for the single-port tag SRAM,
// with an initialization sweep after reset and a one-cycle hit response.
module icache_tag_ctrl
  import icache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               lookup_valid,
  output logic               lookup_ready,
  input  logic [INDEX_W-1:0] lookup_index,
  input  logic [TAG_W-1:0]   lookup_tag,
  output logic               resp_valid,
  output logic               resp_hit,
  input  logic               fill_valid,
  output logic               fill_ready,
  input  logic [INDEX_W-1:0] fill_index,
  input  logic [TAG_W-1:0]   fill_tag,
  input  logic               flush_req,
  output logic               flush_busy,
  output logic               sram_csb,
  output logic               sram_web,
  output logic [INDEX_W-1:0] sram_addr,
  output logic [TAG_W:0]     sram_din,
  input  logic [TAG_W:0]     sram_dout
);

  ctrl_state_e        state_q;
  ctrl_state_e        state_d;
  logic               resp_valid_q;
  logic               resp_valid_d;
  logic [TAG_W-1:0]   tag_q;
  logic [TAG_W-1:0]   tag_d;

  logic               sweep_step_s;
  logic               sweep_restart_s;
  logic [INDEX_W-1:0] sweep_addr_s;
  tag_entry_t         sweep_din_s;
  logic               sweep_done_s;

  logic               lookup_ready_s;
  logic               fill_ready_s;
  logic               lookup_fire_s;
  logic               csb_s;
  logic               web_s;
  logic [INDEX_W-1:0] addr_s;
  tag_entry_t         din_s;

  icache_tag_sweep u_sweep (
    .clk       (clk),
    .rst       (rst),
    .step_i    (sweep_step_s),
    .restart_i (sweep_restart_s),
    .addr_o    (sweep_addr_s),
    .din_o     (sweep_din_s),
    .done_o    (sweep_done_s)
  );

  // Next-state, arbitration and SRAM command decode.
  always_comb begin
    state_d         = state_q;
    sweep_step_s    = 1'b0;
    sweep_restart_s = 1'b0;
    lookup_ready_s  = 1'b0;
    fill_ready_s    = 1'b0;
    lookup_fire_s   = 1'b0;
    csb_s           = 1'b1;
    web_s           = 1'b1;
    addr_s          = {INDEX_W{1'b0}};
    din_s           = make_entry(1'b0, {TAG_W{1'b0}});
    case (state_q)
      ST_SWEEP: begin
        // Write zero to the current index every cycle; flush_req is moot here.
        sweep_step_s = 1'b1;
        csb_s        = 1'b0;
        web_s        = 1'b0;
        addr_s       = sweep_addr_s;
        din_s        = sweep_din_s;
        if (sweep_done_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_SWEEP;
        end
      end
      ST_RUN: begin
        if (flush_req) begin
          // No access this cycle; sweep begins next cycle at index 0.
          sweep_restart_s = 1'b1;
          state_d         = ST_SWEEP;
        end else if (fill_valid) begin
          fill_ready_s = 1'b1;
          csb_s        = 1'b0;
          web_s        = 1'b0;
          addr_s       = fill_index;
          din_s        = make_entry(1'b1, fill_tag);
        end else begin
          lookup_ready_s = 1'b1;
          if (lookup_valid) begin
            lookup_fire_s = 1'b1;
            csb_s         = 1'b0;
            addr_s        = lookup_index;
          end else begin
            lookup_fire_s = 1'b0;
          end
        end
      end
      default: begin
        sweep_restart_s = 1'b1;
        state_d         = ST_SWEEP;
      end
    endcase
  end

  // Response pipeline next values: capture the request tag on acceptance.
  always_comb begin
    resp_valid_d = lookup_fire_s;
    if (lookup_fire_s) begin
      tag_d = lookup_tag;
    end else begin
      tag_d = tag_q;
    end
  end

  // State and response registers; reset drops any pending response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_SWEEP;
      resp_valid_q <= 1'b0;
      tag_q        <= {TAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      resp_valid_q <= resp_valid_d;
      tag_q        <= tag_d;
    end
  end

  // The state register already reads SWEEP during reset, so only the
  // macro strobes need forcing inactive while rst is high.
  assign sram_csb     = csb_s | rst;
  assign sram_web     = web_s | rst;
  assign sram_addr    = addr_s;
  assign sram_din     = din_s;
  assign lookup_ready = lookup_ready_s;
  assign fill_ready   = fill_ready_s;
  assign flush_busy   = (state_q == ST_SWEEP);
  assign resp_valid   = resp_valid_q;
  assign resp_hit     = resp_valid_q && entry_hit(tag_entry_t'(sram_dout), tag_q);

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Self-checking bench for icache_tag_ctrl with a behavioural tag SRAM model
// and a queue-based scoreboard for lookup responses.
module tb_icache_tag_ctrl;
  import icache_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               lookup_valid, lookup_ready;
  logic [INDEX_W-1:0] lookup_index;
  logic [TAG_W-1:0]   lookup_tag;
  logic               resp_valid, resp_hit;
  logic               fill_valid, fill_ready;
  logic [INDEX_W-1:0] fill_index;
  logic [TAG_W-1:0]   fill_tag;
  logic               flush_req, flush_busy;
  logic               sram_csb, sram_web;
  logic [INDEX_W-1:0] sram_addr;
  logic [TAG_W:0]     sram_din;
  logic [TAG_W:0]     sram_dout;

  logic [TAG_W:0]     mem [64];
  int                 cyc = 0;
  int                 n_checks = 0;
  int                 n_errors = 0;

  typedef struct {
    bit hit;
    int due;
  } exp_t;
  exp_t exp_q[$];

  icache_tag_ctrl dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_index(lookup_index), .lookup_tag(lookup_tag),
    .resp_valid(resp_valid), .resp_hit(resp_hit),
    .fill_valid(fill_valid), .fill_ready(fill_ready),
    .fill_index(fill_index), .fill_tag(fill_tag),
    .flush_req(flush_req), .flush_busy(flush_busy),
    .sram_csb(sram_csb), .sram_web(sram_web), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected responses.
  always @(posedge clk) cyc <= cyc + 1;

  // Tag macro model: captures on posedge with csb low, read data next cycle.
  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) mem[sram_addr] <= sram_din;
      else           sram_dout      <= mem[sram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Pops the scoreboard whenever the DUT presents a response.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
      end else if (resp_valid) begin
        if (exp_q.size() == 0) begin
          chk("resp_unexpected", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("resp_cycle", cyc, e.due);
          chk("resp_hit", {31'd0, resp_hit}, {31'd0, e.hit});
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
        e = exp_q.pop_front();
        chk("resp_missing", 32'd0, 32'd1);
      end
    end
  endtask

  // Checks n consecutive sweep cycles starting at index 0.
  task automatic sweep_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("sweep_addr", {26'd0, sram_addr}, i);
      chk("sweep_ctl", {26'd0, flush_busy, sram_csb, sram_web, lookup_ready, fill_ready, (sram_din == '0)},
          32'b100001);
      @(posedge clk); #1;
    end
  endtask

  task automatic do_lookup(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag, input bit exp_hit);
    int t;
    exp_t e;
    lookup_valid = 1'b1; lookup_index = idx; lookup_tag = tag;
    t = 0;
    @(negedge clk);
    while (!lookup_ready && t < 200) begin @(negedge clk); t++; end
    if (!lookup_ready) begin
      chk("lookup_timeout", 32'd0, 32'd1);
    end else begin
      e.hit = exp_hit; e.due = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
  endtask

  task automatic do_fill(input logic [INDEX_W-1:0] idx, input logic [TAG_W-1:0] tag);
    int t;
    fill_valid = 1'b1; fill_index = idx; fill_tag = tag;
    t = 0;
    @(negedge clk);
    while (!fill_ready && t < 200) begin @(negedge clk); t++; end
    if (!fill_ready) chk("fill_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    fill_valid = 1'b0;
  endtask

  task automatic pulse_flush();
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_cycle_ctl", {29'd0, sram_csb, lookup_ready, fill_ready}, 32'b100);
    @(posedge clk); #1;
    flush_req = 1'b0;
  endtask

  task automatic drain();
    repeat (3) begin @(posedge clk); #1; end
    chk("scoreboard_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    // Garbage valid contents: only the sweep can make these entries miss.
    for (int i = 0; i < 64; i++) mem[i] = {1'b1, 22'(i)};
    sram_dout = '0;
    rst = 1'b1;
    lookup_valid = 1'b0; lookup_index = '0; lookup_tag = '0;
    fill_valid = 1'b0; fill_index = '0; fill_tag = '0;
    flush_req = 1'b0;
    fork
      monitor();
    join_none

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {25'd0, lookup_ready, fill_ready, resp_valid, resp_hit, sram_csb, sram_web, flush_busy},
        32'b0000111);
    rst = 1'b0;

    // Initial sweep: 64 cycles, then lookups accepted; index 5 misses
    sweep_check(64);
    @(negedge clk);
    chk("run_after_sweep", {30'd0, flush_busy, lookup_ready}, 32'b01);
    @(posedge clk); #1;
    do_lookup(6'd5, 22'h5, 1'b0);
    drain();

    // Fill then lookup next cycle (read-after-write), hit then tag-mismatch miss back to back
    do_fill(6'd3, 22'h2ABCDE);
    do_lookup(6'd3, 22'h2ABCDE, 1'b1);
    do_lookup(6'd3, 22'h2ABCDF, 1'b0);
    drain();

    // Fill and lookup together: fill wins, lookup follows, then response
    fill_valid = 1'b1; fill_index = 6'd10; fill_tag = 22'h155555;
    lookup_valid = 1'b1; lookup_index = 6'd10; lookup_tag = 22'h155555;
    @(negedge clk);
    chk("fill_priority", {30'd0, fill_ready, lookup_ready}, 32'b10);
    @(posedge clk); #1;
    fill_valid = 1'b0;
    @(negedge clk);
    chk("lookup_after_fill", {31'd0, lookup_ready}, 32'd1);
    begin
      exp_t e;
      e.hit = 1'b1; e.due = cyc + 1;
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    lookup_valid = 1'b0;
    drain();

    // Fill 0/7/63, confirm, flush, then all miss
    do_fill(6'd0, 22'h000001);
    do_fill(6'd7, 22'h3FFFFF);
    do_fill(6'd63, 22'h012345);
    do_lookup(6'd0, 22'h000001, 1'b1);
    do_lookup(6'd63, 22'h012345, 1'b1);
    drain();
    pulse_flush();
    sweep_check(64);
    do_lookup(6'd0, 22'h000001, 1'b0);
    do_lookup(6'd7, 22'h3FFFFF, 1'b0);
    do_lookup(6'd63, 22'h012345, 1'b0);
    drain();

    // Flush and fill together: sweep first, fill installs on the first RUN cycle
    do_fill(6'd9, 22'h0A5A5A);
    fill_valid = 1'b1; fill_index = 6'd9; fill_tag = 22'h2F0F0F;
    flush_req = 1'b1;
    @(negedge clk);
    chk("flush_over_fill", {30'd0, fill_ready, sram_csb}, 32'b01);
    @(posedge clk); #1;
    flush_req = 1'b0;
    sweep_check(64);
    @(negedge clk);
    chk("fill_after_sweep", {30'd0, fill_ready, sram_web}, 32'b10);
    chk("fill_after_sweep_addr", {26'd0, sram_addr}, 32'd9);
    chk("fill_after_sweep_din", {9'd0, sram_din}, {9'd0, 1'b1, 22'h2F0F0F});
    @(posedge clk); #1;
    fill_valid = 1'b0;
    do_lookup(6'd9, 22'h2F0F0F, 1'b1);
    do_lookup(6'd9, 22'h0A5A5A, 1'b0);
    drain();

    // Reset in the middle of a sweep at index 30
    pulse_flush();
    sweep_check(30);
    @(negedge clk);
    chk("sweep_at_30", {26'd0, sram_addr}, 32'd30);
    #1 rst = 1'b1;
    #1;
    chk("midsweep_reset", {25'd0, lookup_ready, fill_ready, resp_valid, resp_hit, sram_csb, sram_web, flush_busy},
        32'b0000111);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    sweep_check(64);
    do_lookup(6'd9, 22'h2F0F0F, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
